axi_lite_regfile_slave: RTL and testbench

Parametrised AXI4-Lite slave register file, the next generation of our 4-register AXI-Lite slave. It provides NUM_REGS registers of DATA_WIDTH bits, with byte-strobe writes and independent AW/W acceptance. Read-only status registers are sourced from fabric, and out-of-range or illegal accesses return SLVERR. It sits between the AXI-Lite interconnect and the control/status logic of a peripheral.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_wr_ctrl.sv | 125 ++++++++++++
 rtl/axi_lite_regfile_slave.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, write FSM states and width helper
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_COLLECT = 2'd0,
      WR_COMMIT  = 2'd1,
      WR_RESP    = 2'd2
   } wr_state_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// rtl/axi_lite_wr_ctrl.sv - AW/W capture, write commit decision and B channel
module axi_lite_wr_ctrl
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   localparam int LSB = clog2(DATA_WIDTH / 8),
   localparam int IDX_W = ADDR_WIDTH - LSB
) (
   input  logic                    ACLK,
   input  logic                    ARST_N,
   input  logic                    en,
   input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
   input  logic                    AW_VALID,
   output logic                    AW_READY,
   input  logic [DATA_WIDTH-1:0]   W_DATA,
   input  logic [DATA_WIDTH/8-1:0] W_STRB,
   input  logic                    W_VALID,
   output logic                    W_READY,
   output logic [1:0]              B_RESP,
   output logic                    B_VALID,
   input  logic                    B_READY,
   output logic                    commit,
   output logic [IDX_W-1:0]        idx,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [DATA_WIDTH/8-1:0] strb
);

   localparam int SLOTS = 1 << IDX_W;
   // RO mask widened to every decodable index so it can be indexed directly
   localparam logic [SLOTS-1:0] RO_PAD = SLOTS'(RO_MASK);

   wr_state_t                 state_q;
   wr_state_t                 state_d;
   logic                      aw_held_q;
   logic                      w_held_q;
   logic [IDX_W-1:0]          idx_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [DATA_WIDTH/8-1:0]   strb_q;
   logic                      aw_hs;
   logic                      w_hs;
   logic                      b_hs;
   logic                      idx_rw;
   logic [31:0]               idx_ext;
   logic                      unused_aw_low;

   assign unused_aw_low = ^AW_ADDR[LSB-1:0];

   assign AW_READY = en & ~aw_held_q;
   assign W_READY  = en & ~w_held_q;
   assign aw_hs    = AW_VALID & AW_READY;
   assign w_hs     = W_VALID & W_READY;

   // B_VALID comes only from FSM state, never from B_READY
   assign B_VALID  = (state_q != WR_COLLECT);
   assign b_hs     = B_VALID & B_READY;

   // held index is stable from commit until the B handshake, so the response
   // can be decoded from it combinationally
   assign idx_ext  = 32'(idx_q);
   assign idx_rw   = (idx_ext < 32'(NUM_REGS)) & ~RO_PAD[idx_q];
   assign B_RESP   = B_VALID ? (idx_rw ? RESP_OKAY : RESP_SLVERR) : RESP_OKAY;

   assign commit   = (state_q == WR_COMMIT) & idx_rw;
   assign idx      = idx_q;
   assign data     = data_q;
   assign strb     = strb_q;

   // capture AW and W payloads independently; both released on the B handshake
   always_ff @(posedge ACLK or negedge ARST_N) begin
      if (!ARST_N) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else if (b_hs) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            idx_q     <= AW_ADDR[ADDR_WIDTH-1:LSB];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            data_q   <= W_DATA;
            strb_q   <= W_STRB;
         end
      end
   end

   // write FSM state register
   always_ff @(posedge ACLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q <= WR_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // commit one cycle after both halves are held, then wait for B_READY
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WR_COLLECT: begin
            if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
               state_d = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            state_d = B_READY ? WR_COLLECT : WR_RESP;
         end
         WR_RESP: begin
            if (B_READY) begin
               state_d = WR_COLLECT;
            end
         end
         default: state_d = WR_COLLECT;
      endcase
   end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// rtl/axi_lite_regfile_slave.sv - AXI4-Lite register file with RO status slots and SLVERR decode
module axi_lite_regfile_slave
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                             ACLK,
   input  logic                             ARST_N,
   input  logic [ADDR_WIDTH-1:0]            AW_ADDR,
   input  logic                             AW_VALID,
   output logic                             AW_READY,
   input  logic [DATA_WIDTH-1:0]            W_DATA,
   input  logic [DATA_WIDTH/8-1:0]          W_STRB,
   input  logic                             W_VALID,
   output logic                             W_READY,
   output logic [1:0]                       B_RESP,
   output logic                             B_VALID,
   input  logic                             B_READY,
   input  logic [ADDR_WIDTH-1:0]            AR_ADDR,
   input  logic                             AR_VALID,
   output logic                             AR_READY,
   output logic [DATA_WIDTH-1:0]            R_DATA,
   output logic [1:0]                       R_RESP,
   output logic                             R_VALID,
   input  logic                             R_READY,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   REG_OUT,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   REG_IN,
   output logic [NUM_REGS-1:0]              WR_PULSE
);

   localparam int LSB    = clog2(DATA_WIDTH / 8);
   localparam int IDX_W  = ADDR_WIDTH - LSB;
   localparam int STRB_W = DATA_WIDTH / 8;

   logic                    en_q;
   logic                    wr_commit;
   logic [IDX_W-1:0]        wr_idx;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [STRB_W-1:0]       wr_strb;
   logic [31:0]             wr_idx_ext;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [IDX_W-1:0]        rd_idx;
   logic [31:0]             rd_idx_ext;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic [1:0]              rd_resp;
   logic                    ar_hs;
   logic                    r_valid_q;
   logic [DATA_WIDTH-1:0]   r_data_q;
   logic [1:0]              r_resp_q;
   logic                    unused_bits;

   // RW slots ignore REG_IN and the byte offset bits are not decoded
   assign unused_bits = ^{REG_IN, AR_ADDR[LSB-1:0]};

   // READYs stay low until the first clock edge after reset release
   always_ff @(posedge ACLK or negedge ARST_N) begin
      if (!ARST_N) begin
         en_q <= 1'b0;
      end else begin
         en_q <= 1'b1;
      end
   end

   axi_lite_wr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK)
   ) u_wr_ctrl (
      .ACLK     (ACLK),
      .ARST_N   (ARST_N),
      .en       (en_q),
      .AW_ADDR  (AW_ADDR),
      .AW_VALID (AW_VALID),
      .AW_READY (AW_READY),
      .W_DATA   (W_DATA),
      .W_STRB   (W_STRB),
      .W_VALID  (W_VALID),
      .W_READY  (W_READY),
      .B_RESP   (B_RESP),
      .B_VALID  (B_VALID),
      .B_READY  (B_READY),
      .commit   (wr_commit),
      .idx      (wr_idx),
      .data     (wr_data),
      .strb     (wr_strb)
   );

   assign wr_idx_ext = 32'(wr_idx);

   // byte-strobed update of the addressed RW register on a legal commit
   always_ff @(posedge ACLK or negedge ARST_N) begin
      if (!ARST_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx_ext == 32'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // one-hot pulse for the register committed this cycle (fires even with zero strobes)
   always_comb begin
      WR_PULSE = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_commit && (wr_idx_ext == 32'(i))) begin
            WR_PULSE[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   assign AR_READY   = en_q & ~r_valid_q;
   assign ar_hs      = AR_VALID & AR_READY;
   assign rd_idx     = AR_ADDR[ADDR_WIDTH-1:LSB];
   assign rd_idx_ext = 32'(rd_idx);

   // read mux: status input for RO slots, stored value for RW, zero/SLVERR beyond range
   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx_ext == 32'(i)) begin
            rd_resp = RESP_OKAY;
            rd_val  = RO_MASK[i] ? REG_IN[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
         end
      end
   end

   // R channel: registered data one cycle after AR, held until R_READY
   always_ff @(posedge ACLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         r_valid_q <= 1'b1;
         r_data_q  <= rd_val;
         r_resp_q  <= rd_resp;
      end else if (r_valid_q && R_READY) begin
         r_valid_q <= 1'b0;
      end
   end

   assign R_VALID = r_valid_q;
   assign R_DATA  = r_data_q;
   assign R_RESP  = r_resp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb/tb_axi_lite_regfile_slave.sv - scoreboard bench for the AXI4-Lite register file
module tb_axi_lite_regfile_slave;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam logic [NR-1:0] RO = 8'h01;

   logic              ACLK = 1'b0;
   logic              ARST_N = 1'b0;
   logic [AW-1:0]     AW_ADDR = '0;
   logic              AW_VALID = 1'b0;
   logic              AW_READY;
   logic [DW-1:0]     W_DATA = '0;
   logic [DW/8-1:0]   W_STRB = '0;
   logic              W_VALID = 1'b0;
   logic              W_READY;
   logic [1:0]        B_RESP;
   logic              B_VALID;
   logic              B_READY = 1'b1;
   logic [AW-1:0]     AR_ADDR = '0;
   logic              AR_VALID = 1'b0;
   logic              AR_READY;
   logic [DW-1:0]     R_DATA;
   logic [1:0]        R_RESP;
   logic              R_VALID;
   logic              R_READY = 1'b1;
   logic [NR*DW-1:0]  REG_OUT;
   logic [NR*DW-1:0]  REG_IN;
   logic [NR-1:0]     WR_PULSE;

   int                n_chk = 0;
   int                n_err = 0;
   logic [1:0]        b_q [$];
   logic [33:0]       r_q [$];
   logic [31:0]       model  [NR];
   logic [31:0]       status [NR];

   axi_lite_regfile_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .RO_MASK    (RO)
   ) dut (
      .ACLK     (ACLK),
      .ARST_N   (ARST_N),
      .AW_ADDR  (AW_ADDR),
      .AW_VALID (AW_VALID),
      .AW_READY (AW_READY),
      .W_DATA   (W_DATA),
      .W_STRB   (W_STRB),
      .W_VALID  (W_VALID),
      .W_READY  (W_READY),
      .B_RESP   (B_RESP),
      .B_VALID  (B_VALID),
      .B_READY  (B_READY),
      .AR_ADDR  (AR_ADDR),
      .AR_VALID (AR_VALID),
      .AR_READY (AR_READY),
      .R_DATA   (R_DATA),
      .R_RESP   (R_RESP),
      .R_VALID  (R_VALID),
      .R_READY  (R_READY),
      .REG_OUT  (REG_OUT),
      .REG_IN   (REG_IN),
      .WR_PULSE (WR_PULSE)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [33:0] exp_read(input logic [5:0] a);
      int i;
      i = int'(a[5:2]);
      if (i >= NR) return {2'b10, 32'h0};
      if (RO[i]) return {2'b00, status[i]};
      return {2'b00, model[i]};
   endfunction

   // scoreboard: pop expected responses when the DUT completes a handshake
   always @(negedge ACLK) begin
      logic [1:0]  eb;
      logic [33:0] er;
      if (ARST_N && B_VALID && B_READY) begin
         if (b_q.size() == 0) begin
            chk("b_unexpected", B_VALID, 1'b0);
         end else begin
            eb = b_q.pop_front();
            chk("b_resp", B_RESP, eb);
         end
      end
      if (ARST_N && R_VALID && R_READY) begin
         if (r_q.size() == 0) begin
            chk("r_unexpected", R_VALID, 1'b0);
         end else begin
            er = r_q.pop_front();
            chk("r_resp", R_RESP, er[33:32]);
            chk("r_data", R_DATA, er[31:0]);
         end
      end
   end

   task automatic send_aw(input logic [5:0] a);
      int t;
      t = 0;
      AW_ADDR  = a;
      AW_VALID = 1'b1;
      @(negedge ACLK);
      while (!AW_READY && t < 50) begin
         t++;
         @(negedge ACLK);
      end
      chk("aw_ready", AW_READY, 1'b1);
      @(posedge ACLK);
      #1;
      AW_VALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int t;
      t = 0;
      W_DATA  = d;
      W_STRB  = s;
      W_VALID = 1'b1;
      @(negedge ACLK);
      while (!W_READY && t < 50) begin
         t++;
         @(negedge ACLK);
      end
      chk("w_ready", W_READY, 1'b1);
      @(posedge ACLK);
      #1;
      W_VALID = 1'b0;
   endtask

   task automatic send_ar(input logic [5:0] a);
      int t;
      t = 0;
      AR_ADDR  = a;
      AR_VALID = 1'b1;
      @(negedge ACLK);
      while (!AR_READY && t < 50) begin
         t++;
         @(negedge ACLK);
      end
      chk("ar_ready", AR_READY, 1'b1);
      @(posedge ACLK);
      #1;
      AR_VALID = 1'b0;
   endtask

   // starts and ends at posedge+1; W leads AW by 'lead' cycles
   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
      int         i;
      logic       ok;
      logic [7:0] pulse;
      i  = int'(a[5:2]);
      ok = 1'b0;
      if (i < NR) ok = !RO[i];
      pulse = ok ? 8'(1 << i) : 8'h00;
      b_q.push_back(ok ? 2'b00 : 2'b10);
      fork
         send_w(d, s);
         begin
            repeat (lead) @(posedge ACLK);
            if (lead > 0) #1;
            send_aw(a);
         end
      join
      @(negedge ACLK);
      chk("b_valid_lat", B_VALID, 1'b1);
      chk("wr_pulse", WR_PULSE, pulse);
      if (ok) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
         end
      end
      @(negedge ACLK);
      chk("wr_pulse_off", WR_PULSE, 8'h00);
      if (ok) chk("reg_out", REG_OUT[i*DW +: DW], model[i]);
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_read(input logic [5:0] a);
      r_q.push_back(exp_read(a));
      send_ar(a);
      @(negedge ACLK);
      chk("r_valid_lat", R_VALID, 1'b1);
      @(posedge ACLK);
      #1;
   endtask

   task automatic check_regs();
      for (int i = 0; i < NR; i++) begin
         chk("reg_out_all", REG_OUT[i*DW +: DW], model[i]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [33:0] held;
      logic [31:0] old2;

      for (int i = 0; i < NR; i++) begin
         model[i]  = 32'h0;
         status[i] = (i == 0) ? 32'hCAFEF00D : (32'hA5A50000 | 32'(i));
         REG_IN[i*DW +: DW] = status[i];
      end

      // reset values
      repeat (2) @(negedge ACLK);
      chk("rst_aw_ready", AW_READY, 1'b0);
      chk("rst_w_ready", W_READY, 1'b0);
      chk("rst_ar_ready", AR_READY, 1'b0);
      chk("rst_b_valid", B_VALID, 1'b0);
      chk("rst_r_valid", R_VALID, 1'b0);
      chk("rst_b_resp", B_RESP, 2'b00);
      chk("rst_r_data", R_DATA, 32'h0);
      chk("rst_wr_pulse", WR_PULSE, 8'h00);
      check_regs();
      @(posedge ACLK);
      #1;
      ARST_N = 1'b1;
      @(negedge ACLK);
      chk("rdy_before_edge", AW_READY, 1'b0);
      @(negedge ACLK);
      chk("rdy_after_edge", AW_READY & W_READY & AR_READY, 1'b1);
      @(posedge ACLK);
      #1;

      // basic write/read, AW and W together
      do_write(6'h04, 32'hDEADBEEF, 4'hF, 0);
      do_read(6'h04);
      do_read(6'h05);

      // W leads AW, then a partial strobe update
      do_write(6'h08, 32'h12345678, 4'hF, 3);
      do_write(6'h08, 32'h0000AB00, 4'b0010, 0);
      chk("strb_merge", model[2], 32'h1234AB78);
      do_read(6'h08);

      // out-of-range write and read
      do_write(6'h20, 32'hFFFFFFFF, 4'hF, 0);
      check_regs();
      do_read(6'h3C);

      // read-only slot
      do_write(6'h00, 32'h00000000, 4'hF, 0);
      do_read(6'h00);
      check_regs();

      // zero strobes: pulse and OKAY, contents unchanged
      do_write(6'h0C, 32'h77777777, 4'h0, 1);
      do_read(6'h0C);

      // read issued in the commit cycle returns the pre-write value
      old2 = model[2];
      fork
         do_write(6'h08, 32'h5A5A5A5A, 4'hF, 0);
         begin
            @(posedge ACLK);
            #1;
            r_q.push_back({2'b00, old2});
            send_ar(6'h08);
            @(negedge ACLK);
            chk("same_cycle_rv", R_VALID, 1'b1);
            @(posedge ACLK);
            #1;
         end
      join
      do_read(6'h08);

      // random traffic
      for (int n = 0; n < 12; n++) begin
         logic [5:0]  ra;
         ra = 6'($urandom_range(0, 63));
         do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
         do_read(6'($urandom_range(0, 63)));
      end
      check_regs();

      // backpressure: responses held stable, address channels blocked
      B_READY = 1'b0;
      R_READY = 1'b0;
      do_write(6'h10, 32'h0BADCAFE, 4'hF, 0);
      held = exp_read(6'h04);
      do_read(6'h04);
      for (int n = 0; n < 5; n++) begin
         @(negedge ACLK);
         chk("hold_b_valid", B_VALID, 1'b1);
         chk("hold_b_resp", B_RESP, 2'b00);
         chk("hold_r_valid", R_VALID, 1'b1);
         chk("hold_r_data", R_DATA, held[31:0]);
         chk("hold_r_resp", R_RESP, held[33:32]);
         chk("hold_aw_ready", AW_READY, 1'b0);
         chk("hold_ar_ready", AR_READY, 1'b0);
      end
      @(posedge ACLK);
      #1;
      B_READY = 1'b1;
      R_READY = 1'b1;
      @(negedge ACLK);
      @(negedge ACLK);
      chk("release_aw_ready", AW_READY, 1'b1);
      chk("release_ar_ready", AR_READY, 1'b1);
      chk("release_b_valid", B_VALID, 1'b0);
      chk("release_r_valid", R_VALID, 1'b0);
      @(posedge ACLK);
      #1;

      // reset while B and R are pending
      B_READY = 1'b0;
      R_READY = 1'b0;
      do_write(6'h0C, 32'h55AA55AA, 4'hF, 0);
      do_read(6'h0C);
      chk("pre_rst_b_valid", B_VALID, 1'b1);
      ARST_N = 1'b0;
      #1;
      chk("mid_rst_b_valid", B_VALID, 1'b0);
      chk("mid_rst_r_valid", R_VALID, 1'b0);
      chk("mid_rst_readys", {AW_READY, W_READY, AR_READY}, 3'b000);
      chk("mid_rst_r_data", R_DATA, 32'h0);
      chk("mid_rst_b_resp", B_RESP, 2'b00);
      b_q.delete();
      r_q.delete();
      for (int i = 0; i < NR; i++) model[i] = 32'h0;
      B_READY = 1'b1;
      R_READY = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARST_N = 1'b1;
      @(negedge ACLK);
      chk("rst2_rdy_before", AW_READY, 1'b0);
      @(negedge ACLK);
      chk("rst2_rdy_after", AW_READY & W_READY & AR_READY, 1'b1);
      for (int n = 0; n < 5; n++) begin
         @(negedge ACLK);
         chk("no_stale_b", B_VALID, 1'b0);
         chk("no_stale_r", R_VALID, 1'b0);
      end
      @(posedge ACLK);
      #1;
      check_regs();
      do_read(6'h0C);
      do_write(6'h1C, 32'h01020304, 4'hF, 0);
      do_read(6'h1C);

      repeat (3) @(negedge ACLK);
      chk("b_queue_drained", b_q.size(), 0);
      chk("r_queue_drained", r_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
